// File: rtl/state_sequencer.sv
// SPI-commanded system state sequencer: a mode-0 SPI slave receives command codes that
// walk READY -> LISTEN -> PROCESS -> DONE -> RESULT, and returns a status byte on sdo.
//
// state   | meaning
// READY   | idle, waiting for the LISTEN command
// LISTEN  | acquisition armed, waiting for the PROCESS command
// PROCESS | processing running, waiting for the DONE command
// DONE    | waiting for the result_valid strobe
// RESULT  | result latched and displayed for HOLD_CYCLES, then back to READY
module state_sequencer #(
    parameter logic [23:0] HOLD_CYCLES = 24'd5_000_000,
    parameter logic [15:0] TIMEOUT     = 16'd2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    input  logic [2:0] result,
    input  logic       result_valid,
    output logic [2:0] sys_state,
    output logic [2:0] result_q,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [2:0] S_READY   = 3'b001;
    localparam logic [2:0] S_LISTEN  = 3'b010;
    localparam logic [2:0] S_PROCESS = 3'b011;
    localparam logic [2:0] S_DONE    = 3'b100;
    localparam logic [2:0] S_RESULT  = 3'b101;
    localparam logic [2:0] C_ABORT   = 3'b001;

    logic        sck_s1_q, sck_s2_q, sck_s3_q;
    logic        sdi_s1_q, sdi_s2_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] tmo_cnt_q;
    logic [7:0]  tx_shift_q;
    logic        tx_err_q;
    logic        err_sticky_q;

    logic [2:0]  state_q, state_d;
    logic [2:0]  res_q, res_d;
    logic [23:0] hold_cnt_q, hold_d;
    logic        byte_valid_q, frame_err_q;

    logic        rise, fall, sck_edge, byte_done, tmo_fire;
    logic [7:0]  rx_byte;
    logic [2:0]  code;
    logic        byte_err, byte_moves, step_ok, err_d;

    assign rise      = sck_s2_q & ~sck_s3_q;
    assign fall      = ~sck_s2_q & sck_s3_q;
    assign sck_edge  = rise | fall;
    assign rx_byte   = {rx_shift_q[6:0], sdi_s2_q};
    assign code      = rx_byte[2:0];
    assign byte_done = rise && (bit_cnt_q == 3'd7);
    // A completing rising edge is itself an edge, so it always wins over the timeout.
    assign tmo_fire  = !sck_edge && (bit_cnt_q != 3'd0) && (tmo_cnt_q == TIMEOUT - 16'd1);
    assign err_d     = byte_err | tmo_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
            sdi_s1_q <= 1'b0;
            sdi_s2_q <= 1'b0;
        end else begin
            sck_s1_q <= sck;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            sdi_s1_q <= sdi;
            sdi_s2_q <= sdi_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift_q   <= 8'd0;
            bit_cnt_q    <= 3'd0;
            tmo_cnt_q    <= 16'd0;
            tx_shift_q   <= 8'd0;
            tx_err_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (rise) begin
                rx_shift_q <= rx_byte;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
            end else if (tmo_fire) begin
                rx_shift_q <= 8'd0;
                bit_cnt_q  <= 3'd0;
            end
            if (sck_edge || bit_cnt_q == 3'd0 || tmo_fire)
                tmo_cnt_q <= 16'd0;
            else
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            // Status is refreshed while idle; tx_err_q remembers whether this byte reports the error.
            if (bit_cnt_q == 3'd0) begin
                tx_shift_q <= {2'b10, err_sticky_q, 2'b00, state_q};
                tx_err_q   <= err_sticky_q;
            end else if (fall) begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
            if (err_d)
                err_sticky_q <= 1'b1;
            else if (byte_done && tx_err_q)
                err_sticky_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_READY;
            res_q        <= 3'd0;
            hold_cnt_q   <= 24'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            hold_cnt_q   <= hold_d;
            byte_valid_q <= byte_done;
            frame_err_q  <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        byte_err   = 1'b0;
        byte_moves = 1'b0;
        step_ok    = (state_q == S_READY   && code == S_LISTEN)  ||
                     (state_q == S_LISTEN  && code == S_PROCESS) ||
                     (state_q == S_PROCESS && code == S_DONE);
        hold_d     = (state_q == S_RESULT) ? hold_cnt_q + 24'd1 : 24'd0;
        if (byte_done) begin
            if (rx_byte[7:3] != 5'd0) begin
                byte_err = 1'b1;
            end else if (code == C_ABORT) begin
                state_d    = S_READY;
                byte_moves = 1'b1;
            end else if (code == state_q) begin
                byte_moves = 1'b0;
            end else if (step_ok) begin
                state_d    = code;
                byte_moves = 1'b1;
            end else begin
                byte_err = 1'b1;
            end
        end
        // A byte that moves the state takes precedence over result_valid and hold expiry.
        if (!byte_moves) begin
            if (state_q == S_DONE && result_valid) begin
                state_d = S_RESULT;
                res_d   = result;
            end else if (state_q == S_RESULT && hold_cnt_q == HOLD_CYCLES - 24'd1) begin
                state_d = S_READY;
            end
        end
    end

    always_comb begin
        sys_state  = state_q;
        result_q   = res_q;
        byte_valid = byte_valid_q;
        frame_err  = frame_err_q;
        sdo        = tx_shift_q[7];
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: a bit-level SPI/command model predicts every output each
// clk cycle, and directed byte sequences carry hand-computed literal expectations.
module tb_state_sequencer;

    localparam logic [23:0] HOLD = 24'd100;
    localparam logic [15:0] TMO  = 16'd50;
    localparam int          HALF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic [2:0] result = 3'd0;
    logic       result_valid = 1'b0;
    logic       sdo;
    logic [2:0] sys_state;
    logic [2:0] result_q;
    logic       byte_valid;
    logic       frame_err;

    int tests = 0;
    int fails = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;

    // model state
    int         cyc = 0;
    logic [2:0] m_state = 3'd1;
    logic [2:0] m_res = 3'd0;
    logic       m_sticky = 1'b0;
    logic       m_rep_err = 1'b0;
    logic       m_bv = 1'b0;
    logic       m_fe = 1'b0;
    int         m_bits = 0;
    int         m_idle = 0;
    int         m_enter = 0;
    logic [7:0] m_acc = 8'd0;
    logic [3:0] sck_h = 4'd0;
    logic [3:0] sdi_h = 4'd0;

    state_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .sdo(sdo),
        .result(result), .result_valid(result_valid), .sys_state(sys_state),
        .result_q(result_q), .byte_valid(byte_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs seen at this posedge reach the logic two synchronizer stages later.
    task automatic model_step();
        logic       rise, edge_s, byte_in, moved;
        logic [2:0] code;
        cyc++;
        m_bv = 1'b0;
        m_fe = 1'b0;
        if (reset) begin
            m_state = 3'd1; m_res = 3'd0; m_sticky = 1'b0; m_rep_err = 1'b0;
            m_bits = 0; m_idle = 0; m_acc = 8'd0; sck_h = 4'd0; sdi_h = 4'd0;
            return;
        end
        sck_h   = {sck_h[2:0], sck};
        sdi_h   = {sdi_h[2:0], sdi};
        rise    = sck_h[2] & ~sck_h[3];
        edge_s  = sck_h[2] ^ sck_h[3];
        byte_in = 1'b0;
        moved   = 1'b0;
        if (rise) begin
            if (m_bits == 0) m_rep_err = m_sticky;
            m_acc = {m_acc[6:0], sdi_h[2]};
            m_bits++;
            if (m_bits == 8) begin
                byte_in = 1'b1;
                m_bits  = 0;
            end
        end
        if (edge_s || m_bits == 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == int'(TMO)) begin
                m_fe = 1'b1; m_bits = 0; m_idle = 0;
            end
        end
        if (byte_in) begin
            m_bv = 1'b1;
            code = m_acc[2:0];
            if (m_acc[7:3] != 5'd0) m_fe = 1'b1;
            else if (code == 3'd1) begin m_state = 3'd1; moved = 1'b1; end
            else if (code == m_state) moved = 1'b0;
            else if (m_state >= 3'd1 && m_state <= 3'd3 && int'(code) == int'(m_state) + 1) begin
                m_state = code; moved = 1'b1;
            end else m_fe = 1'b1;
            if (m_rep_err) m_sticky = 1'b0;
        end
        if (!moved) begin
            if (m_state == 3'd4 && result_valid) begin
                m_state = 3'd5; m_res = result; m_enter = cyc;
            end else if (m_state == 3'd5 && (cyc - m_enter) == int'(HOLD)) begin
                m_state = 3'd1;
            end
        end
        if (m_fe) m_sticky = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
        chk("sys_state", {5'd0, sys_state}, {5'd0, m_state});
        chk("result_q", {5'd0, result_q}, {5'd0, m_res});
        chk("byte_valid", {7'd0, byte_valid}, {7'd0, m_bv});
        chk("frame_err", {7'd0, frame_err}, {7'd0, m_fe});
        if (byte_valid === 1'b1) bv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sdi = b[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Full byte; optionally strobes result_valid in the cycle the byte completes.
    task automatic send(input logic [7:0] b, input bit rv_end, input logic [2:0] rv_val,
                        output logic [7:0] st);
        logic [7:0] exp_st;
        exp_st = {2'b10, m_sticky, 2'b00, m_state};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sdi = b[7-i];
            repeat (HALF) @(negedge clk);
            st[7-i] = sdo;
            sck = 1'b1;
            if (rv_end && i == 7) begin
                repeat (2) @(negedge clk);
                result = rv_val;
                result_valid = 1'b1;
                @(negedge clk);
                result_valid = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("status_byte", st, exp_st);
    endtask

    task automatic send_b(input logic [7:0] b);
        logic [7:0] st;
        send(b, 1'b0, 3'd0, st);
    endtask

    task automatic pulse_rv(input logic [2:0] v);
        @(negedge clk);
        result = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    initial begin
        int bv0, fe0;
        logic [7:0] st;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {5'd0, sys_state}, 8'h01);
        chk("reset_result", {5'd0, result_q}, 8'h00);

        bv0 = bv_cnt; fe0 = fe_cnt;
        send_b(8'h02); send_b(8'h03); send_b(8'h04);
        chk("seq_state_done", {5'd0, sys_state}, 8'h04);
        chk("seq_byte_valid_count", 8'(bv_cnt - bv0), 8'd3);
        chk("seq_frame_err_count", 8'(fe_cnt - fe0), 8'd0);

        pulse_rv(3'b011);
        chk("result_entry_state", {5'd0, sys_state}, 8'h05);
        chk("result_entry_value", {5'd0, result_q}, 8'h03);
        repeat (110) @(negedge clk);
        chk("hold_expired_state", {5'd0, sys_state}, 8'h01);
        chk("hold_kept_result", {5'd0, result_q}, 8'h03);

        pulse_rv(3'b111);
        repeat (2) @(negedge clk);
        chk("rv_ignored_ready", {5'd0, sys_state}, 8'h01);

        fe0 = fe_cnt;
        send_b(8'h04);
        chk("skip_err_count", 8'(fe_cnt - fe0), 8'd1);
        chk("skip_err_state", {5'd0, sys_state}, 8'h01);
        send(8'h01, 1'b0, 3'd0, st);
        chk("status_with_err", st, 8'hA1);
        send(8'h01, 1'b0, 3'd0, st);
        chk("status_err_cleared", st, 8'h81);

        fe0 = fe_cnt;
        spi_bits(8'h00, 3);
        repeat (int'(TMO) + 20) @(negedge clk);
        chk("timeout_err_count", 8'(fe_cnt - fe0), 8'd1);
        chk("timeout_bit_cnt", {5'd0, dut.bit_cnt_q}, 8'h00);
        send_b(8'h02);
        chk("after_timeout_listen", {5'd0, sys_state}, 8'h02);

        fe0 = fe_cnt;
        send_b(8'h02);
        chk("noop_no_err", 8'(fe_cnt - fe0), 8'd0);
        send_b(8'h04);
        send_b(8'h83);
        chk("illegal_err_count", 8'(fe_cnt - fe0), 8'd2);
        chk("illegal_state_kept", {5'd0, sys_state}, 8'h02);

        fe0 = fe_cnt;
        send_b(8'h03);
        send_b(8'h01);
        chk("abort_process_state", {5'd0, sys_state}, 8'h01);
        chk("abort_process_no_err", 8'(fe_cnt - fe0), 8'd0);

        send_b(8'h02); send_b(8'h03); send_b(8'h04);
        pulse_rv(3'b101);
        send_b(8'h01);
        chk("abort_result_state", {5'd0, sys_state}, 8'h01);
        chk("abort_result_value", {5'd0, result_q}, 8'h05);

        send_b(8'h02); send_b(8'h03); send_b(8'h04);
        send(8'h01, 1'b1, 3'b110, st);
        chk("abort_beats_rv_state", {5'd0, sys_state}, 8'h01);
        chk("abort_beats_rv_value", {5'd0, result_q}, 8'h05);
        send_b(8'h02); send_b(8'h03); send_b(8'h04);
        send(8'h04, 1'b1, 3'b110, st);
        chk("noop_then_rv_state", {5'd0, sys_state}, 8'h05);
        chk("noop_then_rv_value", {5'd0, result_q}, 8'h06);
        repeat (110) @(negedge clk);

        send_b(8'h02);
        spi_bits(8'h03, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_sdo", {7'd0, sdo}, 8'h00);
        chk("reset_mid_bit_cnt", {5'd0, dut.bit_cnt_q}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mid_state", {5'd0, sys_state}, 8'h01);
        chk("reset_mid_result", {5'd0, result_q}, 8'h00);
        send_b(8'h02);
        chk("after_reset_listen", {5'd0, sys_state}, 8'h02);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 24'd5_000_000: clk cycles the RESULT state is held before returning to READY.
REQ-002 Parameter TIMEOUT, default 16'd2000: clk cycles without a sck edge, mid-byte, before the partial byte is discarded.
REQ-003 clk  in  1  system clock; all logic in this domain.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 sck  in  1  SPI clock from master PIC, mode 0, asynchronous to clk.
REQ-006 sdi  in  1  SPI data from master, MSB first.
REQ-007 sdo  out  1  SPI status byte to master, MSB first.
REQ-008 result  in  3  classification code from processing; 000 = fail.
REQ-009 result_valid  in  1  single-cycle strobe; result is valid in the strobe cycle.
REQ-010 sys_state  out  3  001 READY, 010 LISTEN, 011 PROCESS, 100 DONE, 101 RESULT.
REQ-011 result_q  out  3  latched result, displayed while in RESULT.
REQ-012 byte_valid  out  1  one-cycle pulse per received byte.
REQ-013 frame_err  out  1  one-cycle pulse on an illegal code or a timeout.

Function
REQ-014 sck and sdi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized sck (3rd stage compare).
REQ-015 On a detected rising edge: shift synchronized sdi into rx_shift[7:0] and increment bit_cnt[2:0].
REQ-016 When the rising edge with bit_cnt==7 occurs: byte_valid pulses the next cycle, with rx_byte = assembled byte; bit_cnt wraps to 0.
REQ-017 TX: when bit_cnt==0 and no byte is in progress, load tx_shift = {2'b10, err_sticky, 2'b00, sys_state}; sdo = tx_shift[7]; shift left on each detected falling edge.
REQ-018 err_sticky SHALL set on any frame_err and clear after it has been reported in a transmitted status byte.
REQ-019 Timeout: timeout counter clears on any sck edge and counts while bit_cnt!=0; when it reaches TIMEOUT: bit_cnt<=0, rx_shift discarded, frame_err pulses, no byte_valid.
REQ-020 Code decode: code = rx_byte[2:0]; rx_byte[7:3]!=0 is illegal.
REQ-021 FSM legal byte transitions: READY->LISTEN on 010; LISTEN->PROCESS on 011; PROCESS->DONE on 100.
REQ-022 A code of 001 from any state SHALL abort to READY with result_q unchanged and without frame_err.
REQ-023 A code equal to the current state SHALL be a no-op without frame_err.
REQ-024 Any other code (000, 101-111, skipped step, or a high bit set) SHALL pulse frame_err; the state is unchanged.
REQ-025 DONE->RESULT on result_valid; result_q<=result in the same edge; result_valid in other states is ignored.
REQ-026 RESULT: hold_cnt counts from 0; at hold_cnt==HOLD_CYCLES-1 go to READY next cycle.
REQ-027 SPI bytes received in RESULT SHALL obey REQ-022..024; 001 aborts the hold early.
REQ-028 sys_state updates in the same cycle byte_valid is high (one-cycle latency after the edge detect).
REQ-029 Simultaneous timeout and a completing rising edge: the byte completes and the timeout is suppressed.
REQ-030 Simultaneous result_valid and byte_valid in DONE: the byte is decoded first; if it aborts, result_valid is ignored.

Reset
REQ-031 Synchronous reset: sys_state=001, result_q=000, byte_valid=0, frame_err=0, err_sticky=0, bit_cnt=0, hold_cnt=0, timeout=0, rx/tx shift=0, sdo=0, synchronizers=0.
REQ-032 Reset mid-byte SHALL discard the partial byte; the first complete byte after release is decoded normally.

Verification
REQ-033 Send 0x02, 0x03, 0x04 -> three byte_valid pulses, sys_state 001->010->011->100, no frame_err.
REQ-034 In DONE, result_valid with result=3'b011 -> sys_state=101, result_q=011; after HOLD_CYCLES (use 100) -> sys_state=001, result_q still 011.
REQ-035 In READY, send 0x04 -> frame_err pulse, sys_state stays 001; the next status byte read = 0xA1, the following one = 0x81.
REQ-036 Send 3 bits, then idle for TIMEOUT cycles -> frame_err, bit_cnt=0; then 0x02 -> sys_state=010.
REQ-037 In PROCESS, send 0x01 -> sys_state=001 with no frame_err; in RESULT, 0x01 ends the hold immediately.
REQ-038 Assert reset at bit 5 of a byte -> all outputs at reset values; a subsequent 0x02 -> sys_state=010.
